toggle_pulse_decoder: RTL and testbench

//   Receive end of the toggle-event link. The sending side drives a T flip-flop

---
 rtl/toggle_pulse_decoder.sv | 116 +++++++++++
 tb/tb_toggle_pulse_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_decoder.sv
// Receive end of a toggle-event link: synchronises a sender's toggle level, turns each change
// into a one-cycle pulse, and queues events as a pending count for a valid/ready consumer.
module toggle_pulse_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PEND_W      = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tog_in,
    output logic              pulse_out,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  total_cnt,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int unsigned       InitW    = $clog2(SYNC_STAGES + 2);
    localparam logic [InitW-1:0]  InitLast = InitW'(SYNC_STAGES + 1);
    localparam logic [PEND_W-1:0] MaxPend  = '1;

    typedef enum logic [1:0] {StInit, StIdle, StPend} state_e;

    state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                tog_s;
    logic                tog_prev_q;
    logic                tog_edge;
    logic                pop;
    logic                drop;
    logic [InitW-1:0]    init_cnt_q, init_cnt_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic                pulse_q;
    logic                ovf_q, ovf_d;

    assign tog_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            tog_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
            pend_q     <= '0;
            total_q    <= '0;
            ovf_q      <= 1'b0;
            init_cnt_q <= '0;
            state_q    <= StInit;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tog_in};
            tog_prev_q <= tog_s;
            pulse_q    <= tog_edge;
            pend_q     <= pend_d;
            total_q    <= total_d;
            ovf_q      <= ovf_d;
            init_cnt_q <= init_cnt_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        tog_edge   = (tog_s ^ tog_prev_q) && (state_q != StInit);
        pop        = (state_q == StPend) && evt_ready;
        drop       = tog_edge && !pop && (pend_q == MaxPend);
        pend_d     = pend_q;
        total_d    = total_q + CNT_W'(tog_edge);
        ovf_d      = ovf_q;
        init_cnt_d = init_cnt_q;
        state_d    = state_q;

        // Simultaneous push and pop cancel, so a full queue never drops in that case.
        if (tog_edge && !pop && (pend_q != MaxPend)) begin
            pend_d = pend_q + 1'b1;
        end else if (!tog_edge && pop) begin
            pend_d = pend_q - 1'b1;
        end

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        // The partial cycle in which reset is released is not counted.
        case (state_q)
            StInit: begin
                if (init_cnt_q == InitLast) begin
                    state_d = StIdle;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (tog_edge) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (pend_d == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign pulse_out = pulse_q;
    assign evt_valid = (state_q == StPend);
    assign pend_cnt  = pend_q;
    assign total_cnt = total_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Directed bench for toggle_pulse_decoder: reset masking, latency, queueing, overflow and
// asynchronous reset, with expected values worked out by hand.
module tb_toggle_pulse_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tog_in;
    logic       pulse_out;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] pend_cnt;
    logic [7:0] total_cnt;
    logic       overflow;
    logic       clr_ovf;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    toggle_pulse_decoder #(
        .SYNC_STAGES(2),
        .PEND_W     (4),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tog_in   (tog_in),
        .pulse_out(pulse_out),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .pend_cnt (pend_cnt),
        .total_cnt(total_cnt),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int p, input int v, input int pc,
                             input int tc, input int o);
        check({tag, ".pulse"}, 32'(pulse_out), p);
        check({tag, ".valid"}, 32'(evt_valid), v);
        check({tag, ".pend"}, 32'(pend_cnt), pc);
        check({tag, ".total"}, 32'(total_cnt), tc);
        check({tag, ".ovf"}, 32'(overflow), o);
    endtask

    initial begin
        rst_n     = 1'b0;
        tog_in    = 1'b1;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;

        // 1: level already high through reset release produces no event
        tick(2);
        check_all("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t1.no_pulse", 32'(pulse_out), 0);
        end
        check_all("t1.end", 0, 0, 0, 0, 0);

        // Re-arm with the line low so the next change is a 0->1 toggle
        rst_n  = 1'b0;
        tog_in = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);

        // 2: single toggle, pulse in the cycle after edge k+2
        tog_in = 1'b1;
        tick(1);
        check("t2.lat0", 32'(pulse_out), 0);
        tick(1);
        check("t2.lat1", 32'(pulse_out), 0);
        tick(1);
        check_all("t2.hit", 1, 1, 1, 1, 0);
        tick(1);
        check_all("t2.after", 0, 1, 1, 1, 0);

        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check_all("t2.popped", 0, 0, 0, 1, 0);

        // 3: five queued events then back-to-back pops
        for (int i = 0; i < 5; i++) begin
            tog_in = ~tog_in;
            tick(8);
        end
        check_all("t3.queued", 0, 1, 5, 6, 0);
        evt_ready = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            tick(1);
            check("t3.pop_pend", 32'(pend_cnt), 32'(i));
            check("t3.pop_valid", 32'(evt_valid), (i != 0) ? 1 : 0);
        end
        tick(1);
        check("t3.no_underflow", 32'(pend_cnt), 0);
        evt_ready = 1'b0;

        // 4: saturate the queue, drop one, then clear the sticky flag
        for (int i = 0; i < 15; i++) begin
            tog_in = ~tog_in;
            tick(4);
        end
        check_all("t4.full", 0, 1, 15, 21, 0);
        tog_in = ~tog_in;
        tick(4);
        check_all("t4.drop", 0, 1, 15, 22, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("t4.clr", 32'(overflow), 0);

        // 5a: push and pop on the same edge while full
        tog_in = ~tog_in;
        tick(2);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check_all("t5.pushpop", 1, 1, 15, 23, 0);

        // 5b: drop coincides with clr_ovf; set wins
        tog_in = ~tog_in;
        tick(2);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check_all("t5.setwins", 1, 1, 15, 24, 1);
        tick(1);
        check("t5.sticky", 32'(overflow), 1);

        // 6: async reset mid-operation with three events pending
        evt_ready = 1'b1;
        tick(12);
        evt_ready = 1'b0;
        check("t6.pend3", 32'(pend_cnt), 3);
        #2 rst_n = 1'b0;
        #1 check_all("t6.async", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        // Toggle lands before the second edge after release, inside the masked window
        tog_in = ~tog_in;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("t6.masked", 32'(pulse_out), 0);
        end
        check_all("t6.ignored", 0, 0, 0, 0, 0);
        tog_in = ~tog_in;
        tick(3);
        check_all("t6.live", 1, 1, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
